// File: rtl/alu_sequencer_pkg.sv
// Shared Salamander-4 definitions: ALU opcodes, instruction layout, sequencer states.
package salamander_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_LD  = 3'd6;
  localparam logic [2:0] OP_ST  = 3'd7;

  localparam int unsigned INSTR_ADDR_W = 4;

  typedef struct packed {
    logic [2:0]              op;
    logic                    use_c;
    logic [INSTR_ADDR_W-1:0] addr;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_WBACK   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Program-memory, register-file and ALU bus driven by the sequencer.
interface alu_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_W   = 4
);
  logic [PC_W-1:0]     imem_addr;
  logic [ADDR_W+3:0]   imem_rdata;
  logic [ADDR_W-1:0]   rf_raddr;
  logic [DATA_W-1:0]   rf_rdata;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                alu_ce;
  logic [2:0]          alu_op;
  logic [DATA_W-1:0]   alu_left;
  logic [DATA_W-1:0]   alu_right;
  logic                alu_carry_in;
  logic                alu_carry_out;
  logic [DATA_W-1:0]   alu_result;

  modport master (
    output imem_addr, rf_raddr, rf_we, rf_waddr, rf_wdata,
           alu_ce, alu_op, alu_left, alu_right, alu_carry_in,
    input  imem_rdata, rf_rdata, alu_carry_out, alu_result
  );

  modport slave (
    input  imem_addr, rf_raddr, rf_we, rf_waddr, rf_wdata,
           alu_ce, alu_op, alu_left, alu_right, alu_carry_in,
    output imem_rdata, rf_rdata, alu_carry_out, alu_result
  );
endinterface

// File: rtl/alu_sequencer.sv
// Salamander-4 accumulator sequencer: fetch/decode/execute/writeback around an
// external combinational ALU; owns PC, IR, ACC and the carry flag.
module alu_sequencer
  import salamander_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] acc,
  alu_sequencer_if.master   bus
);

  localparam int unsigned IW = ADDR_W + 4;

  seq_state_e        state;
  logic [PC_W-1:0]   pc;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] acc_q;
  logic              c_q;
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W-1:0] res_q;
  logic              cout_q;
  logic              stop_pend;
  logic              done_q;

  logic [2:0]        ir_op, mem_op;
  logic              ir_use_c;
  logic [ADDR_W-1:0] ir_addr, mem_addr;

  assign ir_op    = ir[IW-1 -: 3];
  assign ir_use_c = ir[ADDR_W];
  assign ir_addr  = ir[ADDR_W-1:0];
  assign mem_op   = bus.imem_rdata[IW-1 -: 3];
  assign mem_addr = bus.imem_rdata[ADDR_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      pc        <= '0;
      ir        <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      opnd_q    <= '0;
      res_q     <= '0;
      cout_q    <= 1'b0;
      stop_pend <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop && (state inside {ST_FETCH, ST_DECODE, ST_EXECUTE}))
        stop_pend <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            stop_pend <= stop;
          end
        end
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          ir    <= bus.imem_rdata;
          state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          opnd_q <= bus.rf_rdata;
          res_q  <= bus.alu_result;
          cout_q <= bus.alu_carry_out;
          state  <= ST_WBACK;
        end
        ST_WBACK: begin
          case (ir_op)
            OP_ADD, OP_SUB: begin
              acc_q <= res_q;
              c_q   <= cout_q;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LD: acc_q <= res_q;
            OP_ST: ;
            default: ;
          endcase
          pc <= pc + PC_W'(1);
          if (&pc) begin
            done_q    <= 1'b1;
            stop_pend <= 1'b0;
            state     <= ST_IDLE;
          end else if (stop_pend || stop) begin
            stop_pend <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = done_q;
  assign acc  = acc_q;

  // The RF read lands during EXECUTE, so the ALU sees it directly there and the
  // registered copy afterwards.
  always_comb begin
    bus.imem_addr    = pc;
    bus.rf_raddr     = (state == ST_DECODE) ? mem_addr : ir_addr;
    bus.rf_we        = (state == ST_WBACK) && (ir_op == OP_ST) && !RST;
    bus.rf_waddr     = ir_addr;
    bus.rf_wdata     = res_q;
    bus.alu_ce       = (state == ST_EXECUTE);
    bus.alu_left     = acc_q;
    bus.alu_right    = (state == ST_EXECUTE) ? bus.rf_rdata : opnd_q;
    bus.alu_carry_in = ir_use_c & c_q;
    bus.alu_op       = '0;
    if (state == ST_DECODE)
      bus.alu_op = mem_op;
    else if (state == ST_EXECUTE || state == ST_WBACK)
      bus.alu_op = ir_op;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: program table with per-instruction expected ACC, a
// scoreboard for ACC commits and register-file writes, and timed corner sequences.
module tb_alu_sequencer;
  import salamander_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start, stop;
  logic       busy, done;
  logic [7:0] acc;

  alu_sequencer_if #(.DATA_W(8), .ADDR_W(4), .PC_W(4)) bus ();

  alu_sequencer #(.DATA_W(8), .ADDR_W(4), .PC_W(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop),
    .busy(busy), .done(done), .acc(acc), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    instr_t     ins;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t       prog [16];
  logic [7:0] imem [16];
  logic [7:0] rf   [16];

  logic [7:0]  exp_acc_q [$];
  logic [11:0] exp_wr_q  [$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_ce = 0, n_we = 0, n_done = 0;
  logic ce_d1 = 1'b0, ce_d2 = 1'b0;

  function automatic logic [8:0] alu_calc(logic [2:0] op, logic [7:0] l, logic [7:0] r, logic cin);
    case (op)
      OP_ADD:  return {1'b0, l} + {1'b0, r} + {8'd0, cin};
      OP_SUB:  return {1'b0, l} - {1'b0, r} + {8'd0, cin};
      OP_AND:  return {1'b0, l & r};
      OP_OR:   return {1'b0, l | r};
      OP_XOR:  return {1'b0, l ^ r};
      OP_NOT:  return {1'b0, ~l};
      OP_LD:   return {1'b0, r};
      default: return {1'b0, l};
    endcase
  endfunction

  always_comb begin
    {bus.alu_carry_out, bus.alu_result} = 9'd0;
    if (bus.alu_ce)
      {bus.alu_carry_out, bus.alu_result} =
        alu_calc(bus.alu_op, bus.alu_left, bus.alu_right, bus.alu_carry_in);
  end

  always @(posedge CLK) begin
    bus.imem_rdata <= imem[bus.imem_addr];
    bus.rf_rdata   <= rf[bus.rf_raddr];
    if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: an instruction whose EXECUTE was seen two falling edges ago has committed.
  always @(negedge CLK) begin
    n_ce   += int'(bus.alu_ce);
    n_we   += int'(bus.rf_we);
    n_done += int'(done);
    if (RST) begin
      ce_d1 <= 1'b0;
      ce_d2 <= 1'b0;
    end else begin
      if (ce_d2) begin
        if (exp_acc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_acc_underflow: got unexpected commit acc=%0h", acc);
        end else
          chk("acc_commit", 32'(acc), 32'(exp_acc_q.pop_front()));
      end
      if (bus.rf_we) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_wr_underflow: got unexpected write r%0d=%0h", bus.rf_waddr, bus.rf_wdata);
        end else
          chk("rf_write", 32'({bus.rf_waddr, bus.rf_wdata}), 32'(exp_wr_q.pop_front()));
      end
      ce_d2 <= ce_d1;
      ce_d1 <= bus.alu_ce;
    end
  end

  task automatic push_exp(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      exp_acc_q.push_back(prog[i].exp_acc);
      if (prog[i].ins.op == OP_ST)
        exp_wr_q.push_back({prog[i].ins.addr, prog[i].exp_acc});
    end
  endtask

  initial begin
    int cyc, ce0, we0, dn0;

    prog[0]  = '{'{OP_LD,  1'b0, 4'd1}, 8'h0F};
    prog[1]  = '{'{OP_ADD, 1'b0, 4'd2}, 8'h00};
    prog[2]  = '{'{OP_ST,  1'b0, 4'd3}, 8'h00};
    prog[3]  = '{'{OP_ADD, 1'b1, 4'd4}, 8'h02};
    prog[4]  = '{'{OP_AND, 1'b0, 4'd4}, 8'h00};
    prog[5]  = '{'{OP_SUB, 1'b0, 4'd4}, 8'hFF};
    prog[6]  = '{'{OP_AND, 1'b0, 4'd1}, 8'h0F};
    prog[7]  = '{'{OP_ADD, 1'b1, 4'd5}, 8'h20};
    prog[8]  = '{'{OP_OR,  1'b0, 4'd6}, 8'hA1};
    prog[9]  = '{'{OP_XOR, 1'b0, 4'd1}, 8'hAE};
    prog[10] = '{'{OP_ST,  1'b0, 4'd7}, 8'hAE};
    prog[11] = '{'{OP_LD,  1'b0, 4'd3}, 8'h00};
    prog[12] = '{'{OP_ADD, 1'b1, 4'd4}, 8'h01};
    prog[13] = '{'{OP_LD,  1'b0, 4'd8}, 8'h80};
    prog[14] = '{'{OP_ADD, 1'b0, 4'd8}, 8'h00};
    prog[15] = '{'{OP_NOT, 1'b0, 4'd0}, 8'hFF};
    for (int i = 0; i < 16; i++) begin
      imem[i] = prog[i].ins;
      rf[i]   = 8'h00;
    end
    rf[1] = 8'h0F; rf[2] = 8'hF1; rf[3] = 8'hAA; rf[4] = 8'h01;
    rf[5] = 8'h10; rf[6] = 8'h81; rf[8] = 8'h80; rf[9] = 8'h55;

    RST = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 0);
    chk("rst_rf_we", 32'(bus.rf_we), 0);
    chk("rst_alu_ce", 32'(bus.alu_ce), 0);
    chk("rst_alu_op", 32'(bus.alu_op), 0);
    RST = 1'b0;

    // Reset during EXECUTE of a store aborts it before any write.
    imem[0] = {OP_ST, 1'b0, 4'd9};
    we0 = n_we;
    @(negedge CLK); #1; start = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK); #1; cyc++; start = 1'b0;
    end while (!bus.alu_ce && cyc < 20);
    chk("rst_test_execute_reached", 32'(bus.alu_ce), 1);
    RST = 1'b1;
    @(negedge CLK); #1;
    RST = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_acc", 32'(acc), 0);
    chk("midrst_imem_addr", 32'(bus.imem_addr), 0);
    repeat (3) @(negedge CLK);
    #1;
    chk("midrst_no_rf_we", 32'(n_we - we0), 0);
    chk("midrst_still_idle", 32'(busy), 0);
    imem[0] = prog[0].ins;

    // Run PC0..PC5; stop raised in DECODE of PC5.
    push_exp(0, 5);
    ce0 = n_ce; dn0 = n_done;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK); #1; cyc++; start = 1'b0;
      if (cyc == 1)  chk("run1_first_fetch_pc", 32'(bus.imem_addr), 0);
      if (cyc == 3)  chk("run1_alu_op_execute", 32'(bus.alu_op), 32'(OP_LD));
      if (cyc == 12) begin
        chk("run1_st_wback_cycle12", 32'(bus.rf_we), 1);
        chk("run1_one_ce_per_instr", 32'(n_ce - ce0), 3);
        chk("run1_no_done_yet", 32'(n_done - dn0), 0);
      end
      if (cyc == 22) begin
        chk("run1_decode_pc5", 32'(bus.imem_addr), 5);
        stop = 1'b1;
      end
      if (cyc == 23) stop = 1'b0;
    end while (busy && cyc < 100);
    chk("run1_idle_cycle", 32'(cyc), 25);
    chk("run1_stop_pc", 32'(bus.imem_addr), 6);
    chk("run1_ce_count", 32'(n_ce - ce0), 6);
    chk("run1_no_done", 32'(n_done - dn0), 0);
    chk("run1_acc_queue_empty", 32'(exp_acc_q.size()), 0);

    // Resume at PC6 with start held while busy; stop and wrap coincide at PC15.
    push_exp(6, 15);
    ce0 = n_ce; dn0 = n_done;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK); #1; cyc++;
      if (cyc == 1)  chk("run2_resume_pc", 32'(bus.imem_addr), 6);
      if (cyc == 5)  chk("run2_start_held_pc7", 32'(bus.imem_addr), 7);
      if (cyc == 21) chk("run2_start_held_pc11", 32'(bus.imem_addr), 11);
      if (cyc == 30) start = 1'b0;
      if (cyc == 38) stop = 1'b1;
      if (cyc == 39) stop = 1'b0;
    end while (busy && cyc < 100);
    chk("run2_idle_cycle", 32'(cyc), 41);
    chk("run2_done_high", 32'(done), 1);
    chk("run2_wrap_pc", 32'(bus.imem_addr), 0);
    chk("run2_acc_not", 32'(acc), 32'h0000_00FF);
    @(negedge CLK); #1;
    chk("run2_done_pulse_width", 32'(n_done - dn0), 1);
    chk("run2_done_low", 32'(done), 0);
    chk("run2_ce_count", 32'(n_ce - ce0), 10);
    chk("run2_still_idle", 32'(busy), 0);

    // start and stop together in IDLE: exactly one instruction.
    push_exp(0, 0);
    ce0 = n_ce; dn0 = n_done;
    start = 1'b1; stop = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK); #1; cyc++;
      start = 1'b0; stop = 1'b0;
    end while (busy && cyc < 100);
    chk("run3_idle_cycle", 32'(cyc), 5);
    chk("run3_single_instr", 32'(n_ce - ce0), 1);
    chk("run3_pc", 32'(bus.imem_addr), 1);
    chk("run3_no_done", 32'(n_done - dn0), 0);
    repeat (3) @(negedge CLK);
    #1;
    chk("final_acc_queue_empty", 32'(exp_acc_q.size()), 0);
    chk("final_wr_queue_empty", 32'(exp_wr_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
